// File: rtl/imm_pkg.sv
// imm_pkg: shared types for the decode-stage immediate generator.
// Format codes, opcode constants and the buffered entry bundle.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHAMT = 3'd6,
      FMT_ZIMM  = 3'd7
   } imm_fmt_e;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Entry fields are sized for the widest legal configuration
   // (RV64, 64-bit tag); narrower builds use the low bits.
   localparam int IMM_W_MAX = 64;
   localparam int TAG_W_MAX = 64;

   typedef struct packed {
      logic [IMM_W_MAX-1:0] imm;
      imm_fmt_e             fmt;
      logic                 illegal;
      logic [TAG_W_MAX-1:0] tag;
   } imm_entry_t;

endpackage

// File: rtl/imm_decode_comb.sv
// imm_decode_comb: pure combinational immediate extractor.
// Produces the extended immediate, its format and an illegal flag.
module imm_decode_comb
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]      instr_i,
   output logic [XLEN-1:0]  imm_o,
   output imm_fmt_e         fmt_o,
   output logic             illegal_o
);

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic            is_shift;
   logic            sh_wide;
   logic [5:0]      shamt;
   logic            sh_ok;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_z;
   logic [XLEN-1:0] imm_sh;

   assign opc = instr_i[6:0];
   assign f3  = instr_i[14:12];

   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

   // Only RV64 OP-IMM has a 6-bit shamt; *W forms stay at 5.
   assign sh_wide = (XLEN == 64) && (opc == OPC_OP_IMM);

   assign shamt = sh_wide ? instr_i[25:20]
                          : {1'b0, instr_i[24:20]};

   // Everything above the shamt must be zero, except the
   // arithmetic-right-shift marker on funct3=101.
   assign sh_ok = sh_wide
      ? ((instr_i[31:26] == 6'b000000) ||
         ((f3 == 3'b101) && (instr_i[31:26] == 6'b010000)))
      : ((instr_i[31:25] == 7'b0000000) ||
         ((f3 == 3'b101) && (instr_i[31:25] == 7'b0100000)));

   assign imm_i  = XLEN'($signed(instr_i[31:20]));
   assign imm_s  = XLEN'($signed({instr_i[31:25],
                                  instr_i[11:7]}));
   assign imm_b  = XLEN'($signed({instr_i[31], instr_i[7],
                                  instr_i[30:25],
                                  instr_i[11:8], 1'b0}));
   assign imm_u  = XLEN'($signed({instr_i[31:12], 12'b0}));
   assign imm_j  = XLEN'($signed({instr_i[31],
                                  instr_i[19:12],
                                  instr_i[20],
                                  instr_i[30:21], 1'b0}));
   assign imm_z  = XLEN'(instr_i[19:15]);
   assign imm_sh = XLEN'(shamt);

   // Opcode-driven selection of immediate, format and legality.
   always_comb begin
      imm_o     = '0;
      fmt_o     = FMT_NONE;
      illegal_o = 1'b0;
      if (instr_i[1:0] != 2'b11) begin
         illegal_o = 1'b1;
      end else begin
         unique case (opc)
            OPC_LOAD, OPC_JALR: begin
               imm_o = imm_i;
               fmt_o = FMT_I;
            end
            OPC_OP_IMM: begin
               if (is_shift) begin
                  imm_o     = imm_sh;
                  fmt_o     = FMT_SHAMT;
                  illegal_o = !sh_ok;
               end else begin
                  imm_o = imm_i;
                  fmt_o = FMT_I;
               end
            end
            OPC_OP_IMM32: begin
               if (XLEN == 32) begin
                  illegal_o = 1'b1;
               end else if (is_shift) begin
                  imm_o     = imm_sh;
                  fmt_o     = FMT_SHAMT;
                  illegal_o = !sh_ok;
               end else if (f3 == 3'b000) begin
                  imm_o = imm_i;
                  fmt_o = FMT_I;
               end
            end
            OPC_STORE: begin
               imm_o = imm_s;
               fmt_o = FMT_S;
            end
            OPC_BRANCH: begin
               imm_o = imm_b;
               fmt_o = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
               imm_o = imm_u;
               fmt_o = FMT_U;
            end
            OPC_JAL: begin
               imm_o = imm_j;
               fmt_o = FMT_J;
            end
            OPC_SYSTEM: begin
               if (f3[2]) begin
                  imm_o = imm_z;
                  fmt_o = FMT_ZIMM;
               end
            end
            default: begin
               imm_o = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a two-entry
// skid buffer behind valid/ready on both sides.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e          state_q;
   imm_entry_t      main_q;
   imm_entry_t      skid_q;
   imm_entry_t      dec_entry;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [XLEN-1:0] dec_imm;
   imm_fmt_e        dec_fmt;
   logic            dec_ill;

   imm_decode_comb #(
      .XLEN (XLEN)
   ) u_dec (
      .instr_i   (in_instr),
      .imm_o     (dec_imm),
      .fmt_o     (dec_fmt),
      .illegal_o (dec_ill)
   );

   // Bundle the decoded fields with the sideband tag.
   always_comb begin
      dec_entry         = '0;
      dec_entry.imm     = IMM_W_MAX'(dec_imm);
      dec_entry.fmt     = dec_fmt;
      dec_entry.illegal = dec_ill;
      dec_entry.tag     = TAG_W_MAX'(in_tag);
   end

   // Handshake FSM; in_ready and out_valid are registered so
   // out_ready never reaches in_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_valid) begin
                  main_q      <= dec_entry;
                  state_q     <= ST_ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ST_ONE: begin
               if (in_valid && !out_ready) begin
                  skid_q     <= dec_entry;
                  state_q    <= ST_FULL;
                  in_ready_q <= 1'b0;
               end else if (in_valid) begin
                  main_q <= dec_entry;
               end else if (out_ready) begin
                  state_q     <= ST_EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  main_q     <= skid_q;
                  state_q    <= ST_ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_imm     = main_q.imm[XLEN-1:0];
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.illegal;
   assign out_tag     = main_q.tag[TAG_W-1:0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving RV32 and RV64
// instances with identical stimulus.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_tag;
   logic        rdy32, rdy64, v32, v64, ill32, ill64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [2:0]  fmt32, fmt64;
   logic [31:0] tag32, tag64;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy32),
      .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(v32), .out_ready(out_ready),
      .out_imm(imm32), .out_fmt(fmt32),
      .out_illegal(ill32), .out_tag(tag32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy64),
      .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(v64), .out_ready(out_ready),
      .out_imm(imm64), .out_fmt(fmt64),
      .out_illegal(ill64), .out_tag(tag64)
   );

   typedef struct {
      logic [63:0] imm32;
      logic [63:0] imm64;
      int          fmt32;
      int          fmt64;
      bit          ill32;
      bit          ill64;
      logic [31:0] tag;
   } exp_t;

   typedef struct {
      logic [31:0] w;
      logic [63:0] imm32;
      logic [63:0] imm64;
      int          fmt32;
      int          fmt64;
      bit          ill32;
      bit          ill64;
   } dir_t;

   exp_t sb[$];
   exp_t exp_cur;
   int   tests = 0;
   int   fails = 0;
   bit   rand_rdy = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference decode straight from the ISA field definitions.
   function automatic void ref_dec(input int xl, input logic [31:0] w,
                                   output logic [63:0] imm,
                                   output int fmt, output bit ill);
      int     op, f3, shw;
      longint sw, v, up;
      op  = int'(w[6:0]);
      f3  = int'(w[14:12]);
      sw  = longint'($signed(w));
      v   = 0;
      fmt = 0;
      ill = 0;
      if (w[1:0] != 2'b11) ill = 1;
      else if (op == 'h1B && xl == 32) ill = 1;
      else if ((op == 'h13 || op == 'h1B) && (f3 == 1 || f3 == 5)) begin
         shw = (xl == 64 && op == 'h13) ? 6 : 5;
         up  = longint'(w) >> (20 + shw);
         v   = (longint'(w) >> 20) % (longint'(1) << shw);
         fmt = 6;
         ill = !(up == 0 || (f3 == 5 && up == (1024 >> shw)));
      end
      else if (op == 'h03 || op == 'h67 || op == 'h13 ||
               (op == 'h1B && f3 == 0)) begin
         v = sw >>> 20; fmt = 1;
      end
      else if (op == 'h23) begin
         v = (sw >>> 25) * 32 + longint'(w[11:7]); fmt = 2;
      end
      else if (op == 'h63) begin
         v = (sw >>> 31) * 4096 + longint'(w[7]) * 2048
           + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
         fmt = 3;
      end
      else if (op == 'h37 || op == 'h17) begin
         v = (sw >>> 12) * 4096; fmt = 4;
      end
      else if (op == 'h6F) begin
         v = (sw >>> 31) * (longint'(1) << 20)
           + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
           + longint'(w[30:21]) * 2;
         fmt = 5;
      end
      else if (op == 'h73 && w[14]) begin
         v = longint'(w[19:15]); fmt = 7;
      end
      imm = (xl == 32) ? (v & 64'hFFFF_FFFF) : v;
   endfunction

   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      ref_dec(32, w, e.imm32, e.fmt32, e.ill32);
      ref_dec(64, w, e.imm64, e.fmt64, e.ill64);
      e.tag = '0;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 10))
         0: w[6:0] = 7'h03;
         1: w[6:0] = 7'h67;
         2: w[6:0] = 7'h13;
         3: w[6:0] = 7'h1B;
         4: w[6:0] = 7'h23;
         5: w[6:0] = 7'h63;
         6: w[6:0] = 7'h37;
         7: w[6:0] = 7'h17;
         8: w[6:0] = 7'h6F;
         9: w[6:0] = 7'h73;
         default: ;
      endcase
      if ((w[6:0] == 7'h13 || w[6:0] == 7'h1B) && $urandom_range(0, 1) == 1) begin
         w[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:26] = 6'h00;
            default: ;
         endcase
      end
      if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom);
      return w;
   endfunction

   // Monitor: pops and compares on output transfers, pushes on input transfers.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && !flush) begin
            chk("in_ready_match", 64'(rdy64), 64'(rdy32));
            if (v32 && out_ready) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL spurious_out: out_valid=1, scoreboard empty");
               end else begin
                  e = sb.pop_front();
                  chk("valid64", 64'(v64), 64'd1);
                  chk("imm32", {32'b0, imm32}, e.imm32);
                  chk("imm64", imm64, e.imm64);
                  chk("fmt32", 64'(fmt32), 64'(e.fmt32));
                  chk("fmt64", 64'(fmt64), 64'(e.fmt64));
                  chk("ill32", 64'(ill32), 64'(e.ill32));
                  chk("ill64", 64'(ill64), 64'(e.ill64));
                  chk("tag32", 64'(tag32), 64'(e.tag));
                  chk("tag64", 64'(tag64), 64'(e.tag));
               end
            end else begin
               chk("valid_match", 64'(v64), 64'(v32));
            end
            if (in_valid && rdy32) begin
               e     = exp_cur;
               e.tag = in_tag;
               sb.push_back(e);
            end
         end else if (rst_n && flush) begin
            sb.delete();
         end
      end
   end

   // Random downstream backpressure when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w, input logic [31:0] tag,
                       input exp_t e);
      bit acc;
      acc      = 0;
      exp_cur  = e;
      in_instr = w;
      in_tag   = tag;
      in_valid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         acc = rdy32;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      tests++;
      if (!acc) begin
         fails++;
         $display("FAIL accept_timeout: tag %h not accepted", tag);
      end
   endtask

   task automatic drain();
      bit done;
      done      = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk);
         #2;
         if (sb.size() == 0 && !v32) begin
            done = 1;
            break;
         end
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL drain: %0d entries outstanding, out_valid=%b",
                  sb.size(), v32);
      end
      align();
   endtask

   dir_t dv[11] = '{
      '{32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 1, 0, 0},
      '{32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3, 3, 0, 0},
      '{32'h4030D093, 64'h3,        64'h3,                6, 6, 0, 0},
      '{32'h02009093, 64'h0,        64'h20,               6, 6, 1, 0},
      '{32'h800000B7, 64'h80000000, 64'hFFFFFFFF80000000, 4, 4, 0, 0},
      '{32'hFFF0809B, 64'h0,        64'hFFFFFFFFFFFFFFFF, 0, 1, 1, 0},
      '{32'h340FD0F3, 64'h1F,       64'h1F,               7, 7, 0, 0},
      '{32'h00000001, 64'h0,        64'h0,                0, 0, 1, 1},
      '{32'h0200909B, 64'h0,        64'h0,                0, 6, 1, 1},
      '{32'hFFDFF06F, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 5, 5, 0, 0},
      '{32'hFE20AC23, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 2, 2, 0, 0}
   };

   initial begin
      exp_t        e;
      logic [31:0] w;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      exp_cur   = model(32'h0);

      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(v32), 64'd0);
      chk("rst_ready", 64'(rdy32), 64'd1);
      chk("rst_imm32", 64'(imm32), 64'd0);
      chk("rst_imm64", imm64, 64'd0);
      chk("rst_fmt", 64'(fmt32), 64'd0);
      chk("rst_ill", 64'(ill32), 64'd0);
      chk("rst_tag", 64'(tag32), 64'd0);
      align();
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // Directed encodings with hand-derived expectations.
      for (int i = 0; i < 11; i++) begin
         e.imm32 = dv[i].imm32;
         e.imm64 = dv[i].imm64;
         e.fmt32 = dv[i].fmt32;
         e.fmt64 = dv[i].fmt64;
         e.ill32 = dv[i].ill32;
         e.ill64 = dv[i].ill64;
         e.tag   = '0;
         send(dv[i].w, 32'h100 + i, e);
      end
      drain();

      // Backpressure: A, B fill the buffer, C waits upstream.
      out_ready = 1'b0;
      send(32'h00500113, 32'hAAAA0001, model(32'h00500113));
      send(32'h00A00193, 32'hBBBB0002, model(32'h00A00193));
      exp_cur  = model(32'hFFF00213);
      in_instr = 32'hFFF00213;
      in_tag   = 32'hCCCC0003;
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_ready_full", 64'(rdy32), 64'd0);
      chk("bp_hold_tag", 64'(tag32), 64'hAAAA0001);
      align();
      @(negedge clk);
      chk("bp_ready_full2", 64'(rdy32), 64'd0);
      chk("bp_hold_tag2", 64'(tag32), 64'hAAAA0001);
      align();
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_nobubble_a", 64'(v32), 64'd1);
      align();
      @(negedge clk);
      chk("bp_nobubble_b", 64'(v32), 64'd1);
      chk("bp_ready_back", 64'(rdy32), 64'd1);
      align();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_nobubble_c", 64'(v32), 64'd1);
      drain();

      // Flush from FULL, with a dropped instruction in the flush cycle.
      out_ready = 1'b0;
      send(32'h00100093, 32'hF0000001, model(32'h00100093));
      send(32'h00200093, 32'hF0000002, model(32'h00200093));
      exp_cur  = model(32'h00300093);
      in_instr = 32'h00300093;
      in_tag   = 32'hF0000003;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      align();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_valid32", 64'(v32), 64'd0);
      chk("flush_valid64", 64'(v64), 64'd0);
      chk("flush_ready", 64'(rdy32), 64'd1);
      align();
      out_ready = 1'b1;
      send(32'h00400093, 32'hF0000004, model(32'h00400093));
      drain();

      // Randomised traffic with random backpressure and gaps.
      rand_rdy = 1;
      for (int i = 0; i < 400; i++) begin
         w = rand_instr();
         if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            align();
         end
         send(w, $urandom, model(w));
      end
      in_valid = 1'b0;
      rand_rdy = 0;
      align();
      drain();

      // Asynchronous reset while FULL.
      out_ready = 1'b0;
      send(32'h800000B7, 32'hD0000001, model(32'h800000B7));
      send(32'hFE000EE3, 32'hD0000002, model(32'hFE000EE3));
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(v32), 64'd0);
      chk("arst_imm32", 64'(imm32), 64'd0);
      chk("arst_imm64", imm64, 64'd0);
      chk("arst_fmt", 64'(fmt64), 64'd0);
      chk("arst_tag", 64'(tag32), 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("arst_ready_after", 64'(rdy32), 64'd1);
      align();
      send(32'h4030D093, 32'hE0000001, model(32'h4030D093));
      chk("arst_latency_valid", 64'(v32), 64'd1);
      chk("arst_latency_tag", 64'(tag32), 64'hE0000001);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
